alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Mode and timekeeping controller for the alarm clock. It consumes the one-second tick from the clock divider and keeps the time of day. It sequences the user modes (run, set time, set alarm) from debounced button pulses. It also owns the alarm ring/snooze state machine that drives the buzzer enable and the display value mux.

## Interface
Parameters:
- SNOOZE_MIN, 5: snooze length in minutes (1..60)
- RING_MAX_S, 60: auto-dismiss time in seconds (1..1023)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick_1s  in  1  one-cycle strobe, once per second
- btn_mode  in  1  one-cycle pulse: advance mode
- btn_sel  in  1  one-cycle pulse: toggle edit field (hours/minutes)
- btn_inc  in  1  one-cycle pulse: increment edit field
- btn_snooze  in  1  one-cycle pulse: snooze while ringing
- alarm_en  in  1  level: alarm armed
- disp_hh  out  5  displayed hours, 0..23
- disp_mm  out  6  displayed minutes, 0..59
- disp_ss  out  6  displayed seconds, 0..59
- mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
- field  out  1  0=minutes, 1=hours (edit target)
- ring  out  1  buzzer enable
- snoozed  out  1  snooze countdown active

## Operation
- Mode FSM: RUN -> SET_TIME -> SET_ALARM -> RUN, one step per btn_mode. Encoding 3 is unreachable; if it occurs, the next clock forces RUN. Entering any mode clears field to 0.
- btn_sel toggles field. It is honoured in SET_TIME and SET_ALARM only.
- Timekeeping applies in RUN and SET_ALARM. On each tick_1s, ss increments; 59 wraps to 0 and carries into mm; mm 59 wraps to 0 and carries into hh; hh 23 wraps to 0.
- SET_TIME:
  - tick_1s is ignored and ss is forced to 0 on entry.
  - btn_inc increments the selected field of the time, with wrap (mm 59->0, hh 23->0) and no carry between fields.
- SET_ALARM: btn_inc increments the selected field of the alarm register (alarm_hh, alarm_mm), with the same wrap and no-carry rule.
- Display mux:
  - RUN and SET_TIME show time.
  - SET_ALARM shows alarm_hh:alarm_mm with disp_ss=0.
- Ring FSM: IDLE, RINGING, SNOOZED.
  - IDLE -> RINGING when alarm_en=1, mode!=SET_TIME, and a tick_1s advances the time to exactly alarm_hh:alarm_mm:00. The ring counter loads 0.
  - RINGING: the ring counter increments per tick_1s.
    - Counter reaching RING_MAX_S -> IDLE.
    - btn_snooze -> SNOOZED; the snooze counter loads SNOOZE_MIN*60.
    - btn_mode -> IDLE (dismiss). This btn_mode does not change mode.
  - SNOOZED: the snooze counter decrements per tick_1s. When it reaches 0 -> RINGING, with the ring counter reset to 0.
  - alarm_en=0 in any state -> IDLE next cycle.
- ring=1 only in RINGING. snoozed=1 only in SNOOZED.
- Counter widths: snooze 12 bits, ring 10 bits.

## Timing
- Reset values (applied immediately on rst):
  - time 00:00:00, alarm 00:00
  - mode=0, field=0
  - ring FSM IDLE, ring=0, snoozed=0
  - all counters 0
- All outputs are registered.
- Time, alarm and display update on the clock edge that samples tick_1s or btn_inc. disp_* reflect the change at that edge.
- ring rises on the edge following the matching tick_1s, i.e. 1 cycle of latency after the time rollover to the alarm time.
- Simultaneous events:
  - btn_mode with btn_inc or btn_sel: the mode change wins and the other pulse is dropped.
  - tick_1s with btn_inc in SET_ALARM: both take effect.
  - btn_snooze with the tick that expires the ring: snooze wins.
  - alarm_en=0 overrides every ring transition.
- An alarm match while already in RINGING or SNOOZED does not restart the state.
- Buttons in RINGING other than btn_snooze and btn_mode act normally.
- Reset mid-ring or mid-snooze returns to IDLE with ring=0 immediately.

## Test plan
- Assert rst during RUN at 12:34:56 while ringing -> all outputs are zero within the same cycle; ring=0; mode=0.
- SET_TIME: set 23:59, then return to RUN, then 60 ticks -> display 00:00:00. In SET_TIME at mm=59, btn_inc -> mm=0 and hh unchanged. Ticks in SET_TIME leave ss=0.
- Alarm 00:02, alarm_en=1, starting from 00:00:00 in RUN: 120 ticks -> ring=1 one cycle after the 120th tick. With RING_MAX_S=60, 60 further ticks -> ring=0.
- SNOOZE_MIN=1:
  - btn_snooze while ringing -> ring=0 and snoozed=1 next cycle.
  - 60 ticks later -> ring=1.
  - Dropping alarm_en while snoozed -> IDLE and snoozed=0.
- btn_mode and btn_inc in the same cycle in SET_TIME -> mode=2, time unchanged. btn_mode while ringing -> ring=0, mode unchanged.
- SET_ALARM with tick_1s and btn_inc (field=minutes) in the same cycle -> the time second advances and alarm_mm increments by 1.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: time-of-day keeper, user mode sequencer and alarm ring/snooze FSM.
// Every output is a register loaded from next-state values, so edits show on the same edge.
module alarm_ctrl #(
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MAX_S = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       btn_mode,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic       btn_snooze,
   input  logic       alarm_en,
   output logic [4:0] disp_hh,
   output logic [5:0] disp_mm,
   output logic [5:0] disp_ss,
   output logic [1:0] mode,
   output logic       field,
   output logic       ring,
   output logic       snoozed
);
   typedef enum logic [1:0] {M_RUN = 2'd0, M_SET_TIME = 2'd1, M_SET_ALARM = 2'd2} mode_e;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_RINGING = 2'd1, R_SNOOZED = 2'd2} ring_e;

   localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);
   localparam logic [9:0]  RING_LIMIT  = 10'(RING_MAX_S);

   mode_e       mode_q, mode_d;
   ring_e       rstate_q, rstate_d;
   logic        field_q, field_d;
   logic [4:0]  hh_q, hh_d, al_hh_q, al_hh_d;
   logic [5:0]  mm_q, mm_d, ss_q, ss_d, al_mm_q, al_mm_d;
   logic [9:0]  ring_cnt_q, ring_cnt_d;
   logic [11:0] snz_cnt_q, snz_cnt_d;
   logic        match_q, match_d;
   logic [4:0]  disp_hh_q, disp_hh_d;
   logic [5:0]  disp_mm_q, disp_mm_d, disp_ss_q, disp_ss_d;
   logic        ring_q, snoozed_q;
   logic [4:0]  adv_hh;
   logic [5:0]  adv_mm, adv_ss;
   logic        keep_time, mode_step;

   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [4:0] inc24(input logic [4:0] v);
      return (v >= 5'd23) ? 5'd0 : v + 5'd1;
   endfunction

   always_comb begin
      keep_time = (mode_q == M_RUN) || (mode_q == M_SET_ALARM);
      // btn_mode while ringing only dismisses; it never steps the mode.
      mode_step = btn_mode && (rstate_q != R_RINGING);

      adv_hh = hh_q;
      adv_mm = mm_q;
      adv_ss = ss_q;
      if (tick_1s && keep_time) begin
         adv_ss = inc60(ss_q);
         if (ss_q == 6'd59) begin
            adv_mm = inc60(mm_q);
            if (mm_q == 6'd59) adv_hh = inc24(hh_q);
         end
      end
      match_d = alarm_en && tick_1s && keep_time && (adv_hh == al_hh_q)
                && (adv_mm == al_mm_q) && (adv_ss == 6'd0);

      hh_d    = adv_hh;
      mm_d    = adv_mm;
      ss_d    = adv_ss;
      al_hh_d = al_hh_q;
      al_mm_d = al_mm_q;
      field_d = field_q;
      mode_d  = mode_q;
      case (mode_q)
         M_RUN:       if (mode_step) mode_d = M_SET_TIME;
         M_SET_TIME:  if (mode_step) mode_d = M_SET_ALARM;
         M_SET_ALARM: if (mode_step) mode_d = M_RUN;
         default:     mode_d = M_RUN;
      endcase

      if (mode_d != mode_q) begin
         field_d = 1'b0;
         if (mode_d == M_SET_TIME) ss_d = 6'd0;
      end else if (mode_q == M_SET_TIME || mode_q == M_SET_ALARM) begin
         if (btn_inc && mode_q == M_SET_TIME) begin
            if (field_q) hh_d = inc24(hh_q);
            else         mm_d = inc60(mm_q);
         end
         if (btn_inc && mode_q == M_SET_ALARM) begin
            if (field_q) al_hh_d = inc24(al_hh_q);
            else         al_mm_d = inc60(al_mm_q);
         end
         if (btn_sel) field_d = ~field_q;
      end

      rstate_d   = rstate_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      if (!alarm_en) begin
         rstate_d = R_IDLE;
      end else begin
         case (rstate_q)
            R_IDLE: if (match_q) begin
               rstate_d   = R_RINGING;
               ring_cnt_d = '0;
            end
            R_RINGING: begin
               if (btn_snooze) begin
                  rstate_d  = R_SNOOZED;
                  snz_cnt_d = SNOOZE_LOAD;
               end else if (btn_mode) begin
                  rstate_d = R_IDLE;
               end else if (tick_1s) begin
                  ring_cnt_d = ring_cnt_q + 10'd1;
                  if (ring_cnt_q + 10'd1 == RING_LIMIT) rstate_d = R_IDLE;
               end
            end
            R_SNOOZED: if (tick_1s) begin
               snz_cnt_d = snz_cnt_q - 12'd1;
               if (snz_cnt_q == 12'd1) begin
                  rstate_d   = R_RINGING;
                  ring_cnt_d = '0;
               end
            end
            default: rstate_d = R_IDLE;
         endcase
      end

      if (mode_d == M_SET_ALARM) begin
         disp_hh_d = al_hh_d;
         disp_mm_d = al_mm_d;
         disp_ss_d = 6'd0;
      end else begin
         disp_hh_d = hh_d;
         disp_mm_d = mm_d;
         disp_ss_d = ss_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= M_RUN;
         rstate_q   <= R_IDLE;
         field_q    <= 1'b0;
         hh_q       <= '0;
         mm_q       <= '0;
         ss_q       <= '0;
         al_hh_q    <= '0;
         al_mm_q    <= '0;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
         match_q    <= 1'b0;
         disp_hh_q  <= '0;
         disp_mm_q  <= '0;
         disp_ss_q  <= '0;
         ring_q     <= 1'b0;
         snoozed_q  <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         rstate_q   <= rstate_d;
         field_q    <= field_d;
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         al_hh_q    <= al_hh_d;
         al_mm_q    <= al_mm_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         match_q    <= match_d;
         disp_hh_q  <= disp_hh_d;
         disp_mm_q  <= disp_mm_d;
         disp_ss_q  <= disp_ss_d;
         ring_q     <= (rstate_d == R_RINGING);
         snoozed_q  <= (rstate_d == R_SNOOZED);
      end
   end

   assign disp_hh = disp_hh_q;
   assign disp_mm = disp_mm_q;
   assign disp_ss = disp_ss_q;
   assign mode    = mode_q;
   assign field   = field_q;
   assign ring    = ring_q;
   assign snoozed = snoozed_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus a randomized run against a
// seconds-of-day reference model.
module tb_alarm_ctrl;
   localparam int SNZ  = 1;
   localparam int RMAX = 60;

   logic       clk = 1'b0;
   logic       rst, tick_1s, btn_mode, btn_sel, btn_inc, btn_snooze, alarm_en;
   logic [4:0] disp_hh;
   logic [5:0] disp_mm, disp_ss;
   logic [1:0] mode;
   logic       field, ring, snoozed;
   logic [21:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: time as seconds of day, alarm as minutes of day.
   int m_t, m_a, m_mode, m_rs, m_rcnt, m_scnt;
   bit m_field, m_pend;

   always #5 clk = ~clk;

   alarm_ctrl #(.SNOOZE_MIN(SNZ), .RING_MAX_S(RMAX)) dut (
      .clk(clk), .rst(rst), .tick_1s(tick_1s), .btn_mode(btn_mode), .btn_sel(btn_sel),
      .btn_inc(btn_inc), .btn_snooze(btn_snooze), .alarm_en(alarm_en),
      .disp_hh(disp_hh), .disp_mm(disp_mm), .disp_ss(disp_ss), .mode(mode),
      .field(field), .ring(ring), .snoozed(snoozed)
   );

   assign obs = {disp_hh, disp_mm, disp_ss, mode, field, ring, snoozed};

   task automatic model_reset();
      m_t = 0; m_a = 0; m_mode = 0; m_rs = 0; m_rcnt = 0; m_scnt = 0;
      m_field = 0; m_pend = 0;
   endtask

   task automatic model_clock(input bit tk, bm, bs, bi, bz, en);
      int t, a, h, m, s;
      bit mstep, keep, pend_n;
      mstep = bm && (m_rs != 1);
      keep  = (m_mode != 1);
      t = m_t;
      a = m_a;
      if (keep && tk) t = (t + 1) % 86400;
      pend_n = en && keep && tk && (t == a * 60);
      if (mstep) begin
         m_mode  = (m_mode + 1) % 3;
         m_field = 0;
         if (m_mode == 1) t = t - t % 60;
      end else if (m_mode != 0) begin
         if (bi && m_mode == 1) begin
            h = t / 3600; m = (t / 60) % 60; s = t % 60;
            if (m_field) h = (h + 1) % 24; else m = (m + 1) % 60;
            t = h * 3600 + m * 60 + s;
         end
         if (bi && m_mode == 2) begin
            h = a / 60; m = a % 60;
            if (m_field) h = (h + 1) % 24; else m = (m + 1) % 60;
            a = h * 60 + m;
         end
         if (bs) m_field = !m_field;
      end
      m_t = t;
      m_a = a;
      if (!en) m_rs = 0;
      else if (m_rs == 0) begin
         if (m_pend) begin m_rs = 1; m_rcnt = 0; end
      end else if (m_rs == 1) begin
         if (bz) begin m_rs = 2; m_scnt = SNZ * 60; end
         else if (bm) m_rs = 0;
         else if (tk) begin
            m_rcnt++;
            if (m_rcnt == RMAX) m_rs = 0;
         end
      end else if (tk) begin
         m_scnt--;
         if (m_scnt == 0) begin m_rs = 1; m_rcnt = 0; end
      end
      m_pend = pend_n;
   endtask

   function automatic logic [21:0] exp_vec();
      logic [4:0] h;
      logic [5:0] m, s;
      if (m_mode == 2) begin
         h = 5'(m_a / 60); m = 6'(m_a % 60); s = 6'd0;
      end else begin
         h = 5'(m_t / 3600); m = 6'((m_t / 60) % 60); s = 6'(m_t % 60);
      end
      return {h, m, s, 2'(m_mode), m_field, (m_rs == 1), (m_rs == 2)};
   endfunction

   // One clock with the given pulses; leaves time at posedge+1 with pulses cleared.
   task automatic step(input bit tk, bm, bs, bi, bz);
      tick_1s = tk; btn_mode = bm; btn_sel = bs; btn_inc = bi; btn_snooze = bz;
      @(posedge clk);
      model_clock(tk, bm, bs, bi, bz, alarm_en);
      #1;
      tick_1s = 0; btn_mode = 0; btn_sel = 0; btn_inc = 0; btn_snooze = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
   endtask

   task automatic incs(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL reset_async: got %h want 0", obs); end
      @(posedge clk); #1;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL reset_held: got %h want 0", obs); end
      #3 rst = 0;
      model_reset();
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_set_time();
      alarm_en = 0;
      step(0, 1, 0, 0, 0);
      n_checks++; if (mode !== 2'd1 || field !== 1'b0) begin n_fail++; $display("FAIL st_enter: got mode %0d field %0d want 1 0", mode, field); end
      incs(59);
      n_checks++; if (disp_mm !== 6'd59) begin n_fail++; $display("FAIL st_mm59: got %0d want 59", disp_mm); end
      step(0, 0, 1, 0, 0);
      n_checks++; if (field !== 1'b1) begin n_fail++; $display("FAIL st_sel: got %0d want 1", field); end
      incs(23);
      n_checks++; if (disp_hh !== 5'd23) begin n_fail++; $display("FAIL st_hh23: got %0d want 23", disp_hh); end
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      n_checks++; if (disp_mm !== 6'd0 || disp_hh !== 5'd23) begin n_fail++; $display("FAIL st_mm_wrap: got %0d:%0d want 23:0", disp_hh, disp_mm); end
      incs(59);
      ticks(3);
      n_checks++; if ({disp_hh, disp_mm, disp_ss} !== {5'd23, 6'd59, 6'd0}) begin n_fail++; $display("FAIL st_ticks_ignored: got %0d:%0d:%0d want 23:59:0", disp_hh, disp_mm, disp_ss); end
      step(0, 1, 0, 1, 0);
      n_checks++; if (mode !== 2'd2 || disp_mm !== 6'd0) begin n_fail++; $display("FAIL st_mode_inc: got mode %0d mm %0d want 2 0", mode, disp_mm); end
      step(0, 1, 0, 0, 0);
      n_checks++; if ({disp_hh, disp_mm, disp_ss} !== {5'd23, 6'd59, 6'd0}) begin n_fail++; $display("FAIL st_time_kept: got %0d:%0d:%0d want 23:59:0", disp_hh, disp_mm, disp_ss); end
      ticks(60);
      n_checks++; if ({disp_hh, disp_mm, disp_ss} !== 17'd0) begin n_fail++; $display("FAIL st_rollover: got %0d:%0d:%0d want 0:0:0", disp_hh, disp_mm, disp_ss); end
      $display("test_set_time done");
   endtask

   task automatic test_alarm_ring();
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      incs(2);
      n_checks++; if ({mode, disp_hh, disp_mm, disp_ss} !== {2'd2, 5'd0, 6'd2, 6'd0}) begin n_fail++; $display("FAIL ar_alarm_disp: got mode %0d %0d:%0d:%0d want 2 0:2:0", mode, disp_hh, disp_mm, disp_ss); end
      step(0, 1, 0, 0, 0);
      alarm_en = 1;
      ticks(119);
      n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ar_early: got %0d want 0", ring); end
      step(1, 0, 0, 0, 0);
      n_checks++; if (ring !== 1'b0 || disp_mm !== 6'd2) begin n_fail++; $display("FAIL ar_latency: got ring %0d mm %0d want 0 2", ring, disp_mm); end
      step(0, 0, 0, 0, 0);
      n_checks++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ar_ring: got %0d want 1", ring); end
      ticks(59);
      n_checks++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ar_ring_59: got %0d want 1", ring); end
      step(1, 0, 0, 0, 0);
      n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ar_autodismiss: got %0d want 0", ring); end
      step(0, 0, 0, 0, 0);
      $display("test_alarm_ring done");
   endtask

   task automatic test_snooze();
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      incs(2);
      step(0, 1, 0, 0, 0);
      ticks(60);
      n_checks++; if (ring !== 1'b1) begin n_fail++; $display("FAIL sn_ring: got %0d want 1", ring); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (ring !== 1'b0 || snoozed !== 1'b1) begin n_fail++; $display("FAIL sn_enter: got ring %0d snoozed %0d want 0 1", ring, snoozed); end
      ticks(59);
      n_checks++; if (ring !== 1'b0 || snoozed !== 1'b1) begin n_fail++; $display("FAIL sn_hold: got ring %0d snoozed %0d want 0 1", ring, snoozed); end
      step(1, 0, 0, 0, 0);
      n_checks++; if (ring !== 1'b1 || snoozed !== 1'b0) begin n_fail++; $display("FAIL sn_rering: got ring %0d snoozed %0d want 1 0", ring, snoozed); end
      step(0, 0, 0, 0, 1);
      alarm_en = 0;
      step(0, 0, 0, 0, 0);
      n_checks++; if (ring !== 1'b0 || snoozed !== 1'b0) begin n_fail++; $display("FAIL sn_disable: got ring %0d snoozed %0d want 0 0", ring, snoozed); end
      alarm_en = 1;
      $display("test_snooze done");
   endtask

   task automatic test_dismiss();
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      incs(2);
      step(0, 1, 0, 0, 0);
      ticks(60);
      n_checks++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ds_ring: got %0d want 1", ring); end
      step(0, 1, 0, 0, 0);
      n_checks++; if (ring !== 1'b0 || mode !== 2'd0) begin n_fail++; $display("FAIL ds_dismiss: got ring %0d mode %0d want 0 0", ring, mode); end
      $display("test_dismiss done");
   endtask

   task automatic test_alarm_tick_inc();
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      n_checks++; if (disp_mm !== 6'd6) begin n_fail++; $display("FAIL ati_alarm: got %0d want 6", disp_mm); end
      step(1, 0, 0, 1, 0);
      n_checks++; if (disp_mm !== 6'd7) begin n_fail++; $display("FAIL ati_inc: got %0d want 7", disp_mm); end
      step(0, 1, 0, 0, 0);
      n_checks++; if ({disp_hh, disp_mm, disp_ss} !== {5'd0, 6'd6, 6'd1}) begin n_fail++; $display("FAIL ati_tick: got %0d:%0d:%0d want 0:6:1", disp_hh, disp_mm, disp_ss); end
      $display("test_alarm_tick_inc done");
   endtask

   task automatic test_random();
      bit tk, bm, bs, bi, bz;
      int bad = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) alarm_en = !alarm_en;
         tk = ($urandom_range(0, 2) == 0);
         bm = ($urandom_range(0, 79) == 0);
         bs = ($urandom_range(0, 29) == 0);
         bi = ($urandom_range(0, 19) == 0);
         bz = ($urandom_range(0, 39) == 0);
         step(tk, bm, bs, bi, bz);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            bad++;
            if (bad <= 10) $display("FAIL rnd_cycle_%0d: got %h want %h", i, obs, exp_vec());
         end
      end
      $display("test_random done");
   endtask

   task automatic test_reset_midring();
      alarm_en = 0;
      rst = 1; #2 rst = 0;
      model_reset();
      @(posedge clk); #1;
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      incs(12);
      step(0, 0, 1, 0, 0);
      incs(33);
      step(0, 1, 0, 0, 0);
      incs(34);
      step(0, 0, 1, 0, 0);
      incs(12);
      step(0, 1, 0, 0, 0);
      alarm_en = 1;
      ticks(60);
      ticks(56);
      n_checks++; if ({disp_hh, disp_mm, disp_ss, ring} !== {5'd12, 6'd34, 6'd56, 1'b1}) begin n_fail++; $display("FAIL rm_setup: got %0d:%0d:%0d ring %0d want 12:34:56 1", disp_hh, disp_mm, disp_ss, ring); end
      rst = 1;
      #1;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL rm_reset: got %h want 0", obs); end
      #2 rst = 0;
      model_reset();
      @(posedge clk); #1;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL rm_after: got %h want 0", obs); end
      $display("test_reset_midring done");
   endtask

   initial begin
      rst = 1; tick_1s = 0; btn_mode = 0; btn_sel = 0; btn_inc = 0; btn_snooze = 0; alarm_en = 0;
      model_reset();
      test_reset();
      test_set_time();
      test_alarm_ring();
      test_snooze();
      test_dismiss();
      test_alarm_tick_inc();
      test_random();
      test_reset_midring();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
